input_page_loader: RTL and testbench
====================================

// Module: input_page_loader
// PURPOSE
// - Upstream feeder for ProcessA's paged input memory (mem1/mem2 side).
// - Accepts a valid/ready word stream and writes each event into one page of a paged BRAM.
// - Counts the entries in each page and queues every closed page.
// - Drives ProcessA's ap_start / nent / read-page / bx per page and retires the page on ap_done.
// PARAMETERS
// DATA_W   32  word width
// ADDR_W   4   address bits within a page; DEPTH = 2**ADDR_W = 16
// PAGE_W   2   page-select bits; PAGES = 2**PAGE_W = 4
// NENT_W   6   entry-count width; must satisfy NENT_W > ADDR_W
// BX_W     2   bunch-crossing tag width
// PORTS
// clk        in   1       clock
// reset      in   1       asynchronous, active-low reset
// s_valid    in   1       input word valid
// s_ready    out  1       loader can accept a word
// s_data     in   DATA_W  input word
// s_last     in   1       last word of the event
// s_bx       in   BX_W    bx tag of the event; sampled with s_last
// mem_ena    out  1       BRAM port-A enable
// mem_wea    out  1       BRAM port-A write enable
// mem_addr   out  ADDR_W  BRAM write address
// mem_page   out  PAGE_W  BRAM write page
// mem_din    out  DATA_W  BRAM write data
// start      out  1       ap_start to ProcessA; level signal
// done_in    in   1       ap_done from ProcessA
// nent_out   out  NENT_W  entries in the page being processed
// page_rd    out  PAGE_W  page ProcessA reads (pageb)
// bx_out     out  BX_W    bx of the page being processed
// overflow   out  1       sticky: a word was dropped because its page was full
// drop_cnt   out  8       dropped-word count; present only with the macro
// BEHAVIOUR
// - Reset (reset=0):
//   - All outputs are 0; wr_ptr=rd_ptr=0; occ=0; cnt=0; FSM is IDLE.
//   - A partially filled page is discarded.
// - Handshake:
//   - s_ready = (occ < PAGES); a word is accepted on an edge where s_valid & s_ready.
//   - This is combinational from registers only.
// - Write path (registered, 1 cycle):
//   - On an accept edge with cnt < DEPTH: mem_ena=mem_wea=1, mem_addr=cnt, mem_page=wr_ptr, mem_din=s_data; cnt++.
//   - mem_ena and mem_wea return to 0 on the next edge unless another word is accepted.
// - Full page:
//   - On an accept with cnt == DEPTH the word is not written.
//   - overflow is set to 1 and held until reset; cnt holds at DEPTH; s_ready is unaffected.
// - Close (accept with s_last=1), all on the same edge:
//   - nent_q[wr_ptr] <= final cnt, including the last word if it is stored; range 1..DEPTH.
//   - bx_q[wr_ptr] <= s_bx; wr_ptr++ (wraps modulo PAGES); cnt <= 0; occ++.
// - FSM states IDLE and RUN:
//   - IDLE -> RUN on the edge where occ > 0.
//     start=1; nent_out=nent_q[rd_ptr]; page_rd=rd_ptr; bx_out=bx_q[rd_ptr].
//   - RUN, done_in=1 on an edge: rd_ptr++ and occ--.
//     - If occ is still > 0 after the decrement: stay in RUN with start held at 1; outputs switch to the new rd_ptr on the same edge.
//     - Otherwise: go to IDLE, start=0; nent_out, page_rd and bx_out hold their last values.
//   - done_in is ignored in IDLE.
// - Timing:
//   - With E0 the close edge: the BRAM write of the last word happens at E1, and start rises at E1.
//   - ProcessA therefore never sees an unwritten entry.
// - Close and done_in on the same edge: occ is unchanged; wr_ptr and rd_ptr both advance.
// - The write page and the read page never coincide while occ < PAGES.
// - With occ == PAGES, s_ready=0 until done_in frees a page; the write of the current page resumes at cnt=0.
// CONFIGURATION
// - Macro LOADER_DROP_COUNT_EN:
//   - Defined: adds the drop_cnt output.
//     - drop_cnt increments on every dropped word and saturates at 255.
//     - Reset clears it to 0; it is never cleared by a close.
//   - Not defined: the drop_cnt port and its logic are absent; overflow behaviour is unchanged.
// TESTING
// - 3-word event with s_bx=2 after reset:
//   - mem writes addr 0,1,2 on page 0; start rises 1 edge after the close.
//   - nent_out=3, page_rd=0, bx_out=2.
//   - done_in pulse -> start=0.
// - 18-word event into DEPTH=16:
//   - 16 writes, overflow=1, nent_out=16.
//   - With the macro, drop_cnt=2.
// - 5 one-word events, done_in held 0:
//   - 4 pages close; s_ready=0 after the 4th close; page_rd=0.
//   - One done_in -> page_rd=1, s_ready=1, and the 5th event is written to page 0.
// - Close and done_in on the same edge with occ=1:
//   - occ stays 1, start stays 1, page_rd advances to the new page.
// - reset=0 mid-event after 7 words:
//   - All outputs 0 asynchronously.
//   - The next event writes from addr 0 on page 0, with nent_out equal to its own count.
// - Back-to-back 16-word events with s_valid=1 every cycle and done_in 4 cycles after each start:
//   - No stall, pages cycle 0,1,2,3,0.
//   - nent_out=16 each time, overflow stays 0.

Source files
------------

// File: rtl/input_page_loader.sv
// ---------------------------------------------------------------------------
// input_page_loader
//
// Upstream feeder for ProcessA's paged input memory. Words arriving on a
// valid/ready stream are written into the current page of a paged BRAM. Each
// event (terminated by s_last) closes its page: the entry count and bx tag
// are queued, and the page is handed to ProcessA through a start/done
// handshake. When ProcessA reports done, the page is retired.
//
// Optional feature: define LOADER_DROP_COUNT_EN to add the drop_cnt output,
// a saturating count of words dropped because their page was full.
//
// Ports
//   clk       clock
//   reset     asynchronous, active-low reset
//   s_valid   input word valid
//   s_ready   loader can accept a word (occupied pages < PAGES)
//   s_data    input word
//   s_last    last word of the event
//   s_bx      bx tag of the event, sampled with s_last
//   mem_ena   BRAM port-A enable
//   mem_wea   BRAM port-A write enable
//   mem_addr  BRAM write address within the page
//   mem_page  BRAM write page
//   mem_din   BRAM write data
//   start     ap_start to ProcessA (level)
//   done_in   ap_done from ProcessA
//   nent_out  entry count of the page being processed
//   page_rd   page ProcessA reads
//   bx_out    bx tag of the page being processed
//   overflow  sticky flag: a word was dropped because its page was full
//   drop_cnt  saturating dropped-word count (LOADER_DROP_COUNT_EN only)
// ---------------------------------------------------------------------------
module input_page_loader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int PAGE_W = 2,
    parameter int NENT_W = 6,
    parameter int BX_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic [BX_W-1:0]   s_bx,
    output logic              mem_ena,
    output logic              mem_wea,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PAGE_W-1:0] mem_page,
    output logic [DATA_W-1:0] mem_din,
    output logic              start,
    input  logic              done_in,
    output logic [NENT_W-1:0] nent_out,
    output logic [PAGE_W-1:0] page_rd,
    output logic [BX_W-1:0]   bx_out,
    output logic              overflow
`ifdef LOADER_DROP_COUNT_EN
    ,
    output logic [7:0]        drop_cnt
`endif
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int PAGES = 1 << PAGE_W;
    localparam logic [NENT_W-1:0] DEPTH_N = NENT_W'(DEPTH);
    localparam logic [PAGE_W:0]   PAGES_O = (PAGE_W + 1)'(PAGES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, stateNext;

    logic [PAGE_W-1:0] wrPtr, rdPtr, rdPtrNext;
    logic [PAGE_W:0]   occ, occNext;
    logic [NENT_W-1:0] cnt, finalCnt;

    logic [NENT_W-1:0] nentQ [PAGES];
    logic [BX_W-1:0]   bxQ   [PAGES];

    logic accept, store, drop, close, retire;

    logic              loadOut;
    logic [PAGE_W-1:0] loadPage;
    logic [NENT_W-1:0] loadNent;
    logic [BX_W-1:0]   loadBx;

    // Stall only when every page is waiting for ProcessA.
    assign s_ready   = (occ < PAGES_O);
    assign accept    = s_valid & s_ready;
    // cnt never exceeds DEPTH, so a word is either stored or dropped.
    assign store     = accept & (cnt < DEPTH_N);
    assign drop      = accept & (cnt == DEPTH_N);
    assign close     = accept & s_last;
    assign finalCnt  = store ? cnt + NENT_W'(1) : cnt;
    assign retire    = (state == RUN) & done_in;
    assign rdPtrNext = rdPtr + PAGE_W'(1);

    // A close and a retire on the same edge cancel out.
    always_comb begin
        occNext = occ;
        if (close && !retire) begin
            occNext = occ + (PAGE_W + 1)'(1);
        end else if (!close && retire) begin
            occNext = occ - (PAGE_W + 1)'(1);
        end
    end

    // ---- write path and page bookkeeping ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            occ      <= '0;
            cnt      <= '0;
            mem_ena  <= 1'b0;
            mem_wea  <= 1'b0;
            mem_addr <= '0;
            mem_page <= '0;
            mem_din  <= '0;
            overflow <= 1'b0;
        end else begin
            mem_ena <= store;
            mem_wea <= store;
            if (store) begin
                mem_addr <= cnt[ADDR_W-1:0];
                mem_page <= wrPtr;
                mem_din  <= s_data;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (close) begin
                wrPtr <= wrPtr + PAGE_W'(1);
                cnt   <= '0;
            end else if (store) begin
                cnt <= cnt + NENT_W'(1);
            end
            occ <= occNext;
            if (retire) begin
                rdPtr <= rdPtrNext;
            end
        end
    end

    // Per-page descriptors; contents are only read for occupied pages.
    always_ff @(posedge clk) begin
        if (close) begin
            nentQ[wrPtr] <= finalCnt;
            bxQ[wrPtr]   <= s_bx;
        end
    end

    // ---- FSM: state register ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // ---- FSM: next state ----
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (occ != '0) stateNext = RUN;
            RUN:  if (done_in && (occNext == '0)) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        loadOut  = 1'b0;
        loadPage = rdPtr;
        case (state)
            IDLE: begin
                if (occ != '0) begin
                    loadOut  = 1'b1;
                    loadPage = rdPtr;
                end
            end
            RUN: begin
                if (done_in && (occNext != '0)) begin
                    loadOut  = 1'b1;
                    loadPage = rdPtrNext;
                end
            end
            default: loadOut = 1'b0;
        endcase
    end

    // The next page to present may be closing on this very edge (close and
    // done with one page occupied); its descriptor is not yet in the queue,
    // so take it straight from the close path.
    always_comb begin
        if (close && (wrPtr == loadPage)) begin
            loadNent = finalCnt;
            loadBx   = s_bx;
        end else begin
            loadNent = nentQ[loadPage];
            loadBx   = bxQ[loadPage];
        end
    end

    assign start = (state == RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nent_out <= '0;
            page_rd  <= '0;
            bx_out   <= '0;
        end else if (loadOut) begin
            nent_out <= loadNent;
            page_rd  <= loadPage;
            bx_out   <= loadBx;
        end
    end

`ifdef LOADER_DROP_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt <= 8'd0;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_input_page_loader.sv
// ---------------------------------------------------------------------------
// tb_input_page_loader
//
// Directed bench for input_page_loader (default parameters: DEPTH 16,
// PAGES 4). Expected BRAM writes and expected page descriptors are pushed
// to queues when words are accepted; a monitor pops writes as the DUT
// issues them, and page descriptors are popped whenever a page is presented
// to ProcessA.
// ---------------------------------------------------------------------------
module tb_input_page_loader;

    logic        clk;
    logic        reset;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic [1:0]  s_bx;
    logic        mem_ena;
    logic        mem_wea;
    logic [3:0]  mem_addr;
    logic [1:0]  mem_page;
    logic [31:0] mem_din;
    logic        start;
    logic        done_in;
    logic [5:0]  nent_out;
    logic [1:0]  page_rd;
    logic [1:0]  bx_out;
    logic        overflow;
`ifdef LOADER_DROP_COUNT_EN
    logic [7:0]  drop_cnt;
`endif

    input_page_loader dut (
        .clk      (clk),
        .reset    (reset),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .s_bx     (s_bx),
        .mem_ena  (mem_ena),
        .mem_wea  (mem_wea),
        .mem_addr (mem_addr),
        .mem_page (mem_page),
        .mem_din  (mem_din),
        .start    (start),
        .done_in  (done_in),
        .nent_out (nent_out),
        .page_rd  (page_rd),
        .bx_out   (bx_out),
        .overflow (overflow)
`ifdef LOADER_DROP_COUNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  page;
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [5:0] nent;
        logic [1:0] page;
        logic [1:0] bx;
    } pg_t;

    wr_t wq[$];
    pg_t pq[$];

    int         checks = 0;
    int         errors = 0;
    int         mCnt   = 0;
    logic [1:0] mWr    = 2'd0;
    logic       mOvf   = 1'b0;
    int         drops  = 0;
    int         stalls = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one accepted word.
    function automatic void modelAccept(input logic [31:0] d, input logic last, input logic [1:0] bx);
        if (mCnt < 16) begin
            wq.push_back('{page: mWr, addr: 4'(mCnt), data: d});
            mCnt++;
        end else begin
            mOvf = 1'b1;
            if (drops < 255) drops++;
        end
        if (last) begin
            pq.push_back('{nent: 6'(mCnt), page: mWr, bx: bx});
            mWr  = mWr + 2'd1;
            mCnt = 0;
        end
    endfunction

    // Write monitor.
    always @(negedge clk) begin
        wr_t e;
        if (mem_ena === 1'b1) begin
            if (wq.size() == 0) begin
                chk("wr_unexpected", 64'(mem_ena), 64'(0));
            end else begin
                e = wq.pop_front();
                chk("wr_wea",  64'(mem_wea),  64'(1));
                chk("wr_page", 64'(mem_page), 64'(e.page));
                chk("wr_addr", 64'(mem_addr), 64'(e.addr));
                chk("wr_data", 64'(mem_din),  64'(e.data));
            end
        end
    end

    // Drive a word and hold it until accepted; leaves s_valid asserted.
    task automatic sendWord(input logic [31:0] d, input logic last, input logic [1:0] bx);
        int n;
        n       = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        s_bx    = bx;
        @(negedge clk);
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            chk("ready_timeout", 64'(s_ready), 64'(1));
            s_valid = 1'b0;
        end else begin
            if (n > 0) stalls++;
            modelAccept(d, last, bx);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic pulseDone();
        done_in = 1'b1;
        @(posedge clk);
        #1;
        done_in = 1'b0;
    endtask

    task automatic checkPage();
        pg_t e;
        if (pq.size() == 0) begin
            chk("pq_underflow", 64'(pq.size()), 64'(1));
        end else begin
            e = pq.pop_front();
            chk("pg_start", 64'(start),    64'(1));
            chk("pg_nent",  64'(nent_out), 64'(e.nent));
            chk("pg_page",  64'(page_rd),  64'(e.page));
            chk("pg_bx",    64'(bx_out),   64'(e.bx));
        end
    endtask

    // Retire the presented page and every queued one, then expect idle.
    task automatic drain();
        int n;
        n = 0;
        pulseDone();
        while (pq.size() > 0 && n < 8) begin
            checkPage();
            pulseDone();
            n++;
        end
        chk("drain_idle", 64'(start), 64'(0));
    endtask

    task automatic doReset();
        #1;
        reset = 1'b0;
        #1;
        chk("rst_start",    64'(start),    64'(0));
        chk("rst_mem_ena",  64'(mem_ena),  64'(0));
        chk("rst_mem_wea",  64'(mem_wea),  64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_mem_page", 64'(mem_page), 64'(0));
        chk("rst_mem_din",  64'(mem_din),  64'(0));
        chk("rst_nent",     64'(nent_out), 64'(0));
        chk("rst_page_rd",  64'(page_rd),  64'(0));
        chk("rst_bx",       64'(bx_out),   64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        chk("rst_s_ready",  64'(s_ready),  64'(1));
`ifdef LOADER_DROP_COUNT_EN
        chk("rst_drop_cnt", 64'(drop_cnt), 64'(0));
`endif
        repeat (2) @(negedge clk);
        reset = 1'b1;
        pq.delete();
        mCnt  = 0;
        mWr   = 2'd0;
        mOvf  = 1'b0;
        drops = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        reset   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        s_bx    = '0;
        done_in = 1'b0;
        doReset();

        // 3-word event, bx 2
        sendWord(32'hA000_0000, 1'b0, 2'd2);
        sendWord(32'hA000_0001, 1'b0, 2'd2);
        sendWord(32'hA000_0002, 1'b1, 2'd2);
        idle();
        chk("t1_start_not_yet", 64'(start), 64'(0));
        @(posedge clk);
        #1;
        checkPage();
        drain();
        chk("t1_nent_hold", 64'(nent_out), 64'(3));
        chk("t1_page_hold", 64'(page_rd),  64'(0));

        // 18-word event into a 16-deep page
        for (int i = 0; i < 18; i++) begin
            sendWord(32'hB000_0000 + 32'(i), (i == 17), 2'd1);
            if (i == 15) chk("t2_ovf_before", 64'(overflow), 64'(0));
            if (i == 16) chk("t2_ovf_set",    64'(overflow), 64'(1));
        end
        idle();
        @(posedge clk);
        #1;
        checkPage();
        chk("t2_overflow", 64'(overflow), 64'(mOvf));
`ifdef LOADER_DROP_COUNT_EN
        chk("t2_drop_cnt", 64'(drop_cnt), 64'(drops));
`endif
        drain();

        // reset mid-event after 7 words
        for (int i = 0; i < 7; i++) sendWord(32'hC000_0000 + 32'(i), 1'b0, 2'd0);
        idle();
        @(negedge clk);
        doReset();
        for (int i = 0; i < 5; i++) sendWord(32'hC100_0000 + 32'(i), (i == 4), 2'd1);
        idle();
        @(posedge clk);
        #1;
        checkPage();
        drain();

        // five one-word events with ProcessA stalled
        doReset();
        for (int k = 0; k < 4; k++) sendWord(32'hD000_0000 + 32'(k), 1'b1, 2'(k));
        chk("t3_ready_full", 64'(s_ready), 64'(0));
        chk("t3_page_rd0",   64'(page_rd), 64'(0));
        checkPage();
        s_data = 32'hD000_0004;
        s_last = 1'b1;
        s_bx   = 2'd3;
        repeat (2) @(posedge clk);
        #1;
        chk("t3_still_full", 64'(s_ready), 64'(0));
        pulseDone();
        chk("t3_ready_freed", 64'(s_ready), 64'(1));
        chk("t3_page_rd1",    64'(page_rd), 64'(1));
        checkPage();
        sendWord(32'hD000_0004, 1'b1, 2'd3);
        idle();
        drain();

        // close and done on the same edge with one page occupied
        doReset();
        sendWord(32'hE000_0000, 1'b0, 2'd3);
        sendWord(32'hE000_0001, 1'b1, 2'd3);
        idle();
        @(posedge clk);
        #1;
        checkPage();
        sendWord(32'hE100_0000, 1'b0, 2'd1);
        s_data  = 32'hE100_0001;
        s_last  = 1'b1;
        s_bx    = 2'd1;
        done_in = 1'b1;
        @(negedge clk);
        chk("t4_ready", 64'(s_ready), 64'(1));
        modelAccept(32'hE100_0001, 1'b1, 2'd1);
        @(posedge clk);
        #1;
        done_in = 1'b0;
        idle();
        checkPage();
        drain();

        // back-to-back full events with ProcessA answering after 4 cycles
        doReset();
        stalls = 0;
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    for (int i = 0; i < 16; i++) begin
                        sendWord(32'hF000_0000 + 32'(k * 256 + i), (i == 15), 2'(k));
                    end
                end
                idle();
            end
            begin
                for (int k = 0; k < 5; k++) begin
                    nb = 0;
                    @(negedge clk);
                    while (!start && nb < 300) begin
                        @(negedge clk);
                        nb++;
                    end
                    if (!start) begin
                        chk("t6_start_timeout", 64'(start), 64'(1));
                    end else begin
                        checkPage();
                        repeat (3) @(posedge clk);
                        #1;
                        done_in = 1'b1;
                        @(posedge clk);
                        #1;
                        done_in = 1'b0;
                    end
                end
            end
        join
        chk("t6_stalls",   64'(stalls),   64'(0));
        chk("t6_overflow", 64'(overflow), 64'(0));
        chk("t6_idle",     64'(start),    64'(0));

        repeat (2) @(posedge clk);
        #1;
        chk("end_wq_empty", 64'(wq.size()), 64'(0));
        chk("end_pq_empty", 64'(pq.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
